gate_truth_table_scanner: RTL
=============================

// Module: gate_truth_table_scanner
// PURPOSE
//  Sequential response-side checker for single-output combinational gates.
//  On start, it drives every input combination to a gate under test and samples the gate output.
//  It assembles the measured truth table and compares it with an expected table.
//  Bench code and gate regressions read the result instead of hand-checking printed tables.
// PARAMETERS
//  N_IN    2        number of gate inputs; vector count V = 2**N_IN (1..4)
//  SETTLE  1        cycles stim is held before resp is sampled (>=1)
//  EXPECT  4'b1000  expected table, bit i = expected resp for stim==i (default = 2-input AND)
// PORTS
//  clk       in   1         single clock, rising edge
//  rst       in   1         asynchronous, active-high reset
//  start     in   1         request a scan; accepted only in IDLE
//  stim      out  N_IN      input vector driven to gate under test
//  resp      in   1         gate output, sampled synchronously
//  busy      out  1         high from accept until the cycle before done
//  done      out  1         one-cycle pulse when a scan completes
//  table_out out  V         measured table, bit i = resp sampled for stim==i
//  pass      out  1         table_out == EXPECT; valid from done until next accept
//  mis_cnt   out  N_IN+1    number of bit positions where table_out != EXPECT
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; stim, busy, done, table_out, pass, mis_cnt all 0.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE   -> SETTLE on start; idx=0, stim=0, table_out=0, pass=0, mis_cnt=0, busy=1.
//   SETTLE : holds stim for exactly SETTLE cycles (down-counter), then -> SAMPLE.
//   SAMPLE : one cycle; table_out[idx] <= resp.
//            If idx==V-1 -> DONE.
//            Else idx++, stim<=idx+1, -> SETTLE.
//   DONE   : done=1 for one cycle; busy=0; pass and mis_cnt registered from the final table; -> IDLE.
//  Latency: the start-accept edge to the done-high cycle is V*(SETTLE+1)+1 cycles.
//   N_IN=2, SETTLE=1: 9 cycles.
//  stim changes only on entry to SETTLE, so it is glitch-free relative to the sample point.
//  start while busy or in DONE is ignored, with no queuing.
//  start held high re-triggers on the first IDLE cycle after DONE.
//  After IDLE is re-entered, table_out, pass and mis_cnt hold until the next accept.
//  idx width is N_IN, and the last vector is detected by compare, so no wrap-around occurs.
//  mis_cnt = popcount(table_out ^ EXPECT), computed combinationally from the final table
//  and registered in DONE; maximum value is V.
//  Reset mid-scan aborts immediately.
//   No done pulse; partial table discarded (cleared to 0).
//  resp is an asynchronous path from a combinational gate, so SETTLE covers its settling.
//   No synchroniser is required since the gate shares clk's domain.
// STRUCTURE
//  Package gate_scan_pkg: state encoding localparams (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3).
//   Also holds a shared popcount function used by mis_cnt.
//  Sub-module settle_timer: loadable down-counter (load, cnt_in, zero flag).
//   It is reusable by other gate-scanning benches.
//  Everything else stays in this module: FSM, idx/stim register, table shift-in, compare.
// TESTING
//  1. Defaults, resp = stim[1]&stim[0], pulse start.
//     -> stim walks 0,1,2,3; done at 9 cycles; table_out=4'b1000, pass=1, mis_cnt=0.
//  2. Defaults, resp = stim[1]|stim[0].
//     -> table_out=4'b1110, pass=0, mis_cnt=2.
//  3. SETTLE=3, AND gate.
//     -> each stim held 3 cycles before sample; done exactly 17 cycles after accept.
//  4. start pulsed while busy and again during the DONE cycle.
//     -> both ignored; exactly one done pulse; busy never drops mid-scan.
//  5. rst asserted while stim==2, not aligned to clk.
//     -> all outputs 0 immediately; no done.
//     -> a fresh start then yields a full correct 4-vector scan.
//  6. N_IN=1, EXPECT=2'b01, resp = ~stim[0] (inverter).
//     -> table_out=2'b01, pass=1; done 5 cycles after accept.

Source files
------------

// File: rtl/gate_truth_table_scanner_pkg.sv
// gate_scan_pkg: shared types and helpers for the gate truth-table scanner.
//   state_e    - scanner FSM state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3)
//   popcount16 - number of set bits in a 16-bit vector (tables are at most 16 wide)
package gate_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/gate_truth_table_scanner_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag.
//   clk, rst : clock, async active-high reset (count clears to 0)
//   load     : load cnt_in (takes priority over dec)
//   dec      : decrement by one
//   cnt_in   : load value
//   zero     : count is zero
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] cnt_in,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = cnt_in;
    else if (dec) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_table_scanner.sv
// gate_truth_table_scanner: walks every input vector of a single-output gate,
// holds each for SETTLE cycles, samples the gate output, and compares the
// assembled truth table against EXPECT.
//   clk, rst  : clock, async active-high reset
//   start     : scan request, honoured only in IDLE
//   stim      : vector driven to the gate under test
//   resp      : gate output
//   busy      : scan in progress (accept through the cycle before done)
//   done      : one-cycle completion pulse
//   table_out : measured table, bit i = resp for stim==i
//   pass      : table_out == EXPECT, valid from done until the next accept
//   mis_cnt   : number of table bits differing from EXPECT
module gate_truth_table_scanner
  import gate_scan_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   resp,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   pass,
  output logic [N_IN:0]          mis_cnt
);

  localparam int V  = 1 << N_IN;
  localparam int CW = N_IN + 1;
  // Timer is loaded with SETTLE-1 so SETTLE cycles elapse before zero is seen.
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST   = N_IN'(V - 1);
  localparam logic [TW-1:0]   T_LOAD = TW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;   // doubles as the vector index
  logic [V-1:0]    table_q, table_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   mis_q, mis_d;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [15:0]     diff;

  settle_timer #(.W(TW)) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .cnt_in (T_LOAD),
    .zero   (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    table_d  = table_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    mis_d    = mis_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    diff     = '0;
    diff[V-1:0] = table_q ^ EXPECT;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          stim_d   = '0;
          table_d  = '0;
          pass_d   = 1'b0;
          mis_d    = '0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) state_d = ST_SAMPLE;
        else          tmr_dec = 1'b1;
      end
      ST_SAMPLE: begin
        table_d[stim_q] = resp;
        if (stim_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          // stim only moves here, on the way back into SETTLE
          stim_d   = stim_q + 1'b1;
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        // table_q is final here; results land together with the done pulse
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (table_q == EXPECT);
        mis_d   = CW'(popcount16(diff));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;
  assign mis_cnt   = mis_q;

endmodule
